// File: rtl/prod_accumulator.sv
// prod_accumulator: sums a stream of unsigned products into grouped results.
// A group closes after LEN products or on in_last, whichever comes first.
// The finished sum, product count and sticky carry flag are held on a
// valid/ready output until the sink takes them. Inputs are not accepted
// while a result is waiting.
module prod_accumulator #(
    parameter  int PROD_W = 16,
    parameter  int ACC_W  = 24,
    parameter  int LEN    = 8,
    localparam int CNT_W  = $clog2(LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam int SUM_W = ACC_W + 1;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    // One extra bit on the adder captures the carry out of the accumulator.
    logic [SUM_W-1:0] sum_ext;
    logic [CNT_W-1:0] cnt_inc;

    assign sum_ext = {1'b0, acc_q} + SUM_W'(in_prod);
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state and handshake logic; state only moves on a handshake, so an
    // undriven in_prod while in_valid is low never reaches the registers.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d = sum_ext[ACC_W-1:0];
                    ovf_d = ovf_q | sum_ext[ACC_W];
                    cnt_d = cnt_inc;
                    // The closing product is part of the result; in_last on
                    // the LEN-th product closes the group only once.
                    if (cnt_inc == CNT_W'(LEN) || in_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State registers; reset discards any partially accumulated group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_acc   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_prod_accumulator.sv
// Testbench for prod_accumulator: directed scenarios plus a randomized
// stream checked against a group-sum scoreboard. A second instance with a
// 16-bit accumulator and LEN=2 exercises the carry flag.
module tb_prod_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // Default-sized instance
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_prod = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_acc;
    logic [3:0]  out_count;
    logic        out_ovf;

    // Reduced instance: ACC_W=16, LEN=2
    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [15:0] s_in_prod = '0;
    logic        s_in_last = 1'b0;
    logic        s_out_valid;
    logic        s_out_ready = 1'b0;
    logic [15:0] s_out_acc;
    logic [1:0]  s_out_count;
    logic        s_out_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    prod_accumulator dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_prod  (in_prod),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_acc  (out_acc),
        .out_count(out_count),
        .out_ovf  (out_ovf)
    );

    prod_accumulator #(.PROD_W(16), .ACC_W(16), .LEN(2)) dut_s (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (s_in_valid),
        .in_ready (s_in_ready),
        .in_prod  (s_in_prod),
        .in_last  (s_in_last),
        .out_valid(s_out_valid),
        .out_ready(s_out_ready),
        .out_acc  (s_out_acc),
        .out_count(s_out_count),
        .out_ovf  (s_out_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one product to the default instance; returns at the negedge
    // after the handshake edge.
    task automatic send(input logic [15:0] p, input logic l);
        int waited;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = l;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'(1));
        @(negedge clk);
        in_valid = 1'b0;
        in_prod  = '0;
        in_last  = 1'b0;
    endtask

    task automatic send_s(input logic [15:0] p, input logic l);
        int waited;
        s_in_valid = 1'b1;
        s_in_prod  = p;
        s_in_last  = l;
        waited     = 0;
        while (!s_in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!s_in_ready) check("send_s_timeout", 32'(s_in_ready), 32'(1));
        @(negedge clk);
        s_in_valid = 1'b0;
        s_in_prod  = '0;
        s_in_last  = 1'b0;
    endtask

    // Wait for a result on the default instance, check it, take it.
    task automatic recv(input string tag, input int exp_acc, input int exp_cnt, input int exp_ovf);
        int waited;
        waited = 0;
        while (!out_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'(1));
        check({tag, "_acc"},   32'(out_acc),   32'(exp_acc));
        check({tag, "_cnt"},   32'(out_count), 32'(exp_cnt));
        check({tag, "_ovf"},   32'(out_ovf),   32'(exp_ovf));
        $display("[TB] %s: acc=%0d count=%0d ovf=%0d", tag, out_acc, out_count, out_ovf);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic recv_s(input string tag, input int exp_acc, input int exp_cnt, input int exp_ovf);
        int waited;
        waited = 0;
        while (!s_out_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_valid"}, 32'(s_out_valid), 32'(1));
        check({tag, "_acc"},   32'(s_out_acc),   32'(exp_acc));
        check({tag, "_cnt"},   32'(s_out_count), 32'(exp_cnt));
        check({tag, "_ovf"},   32'(s_out_ovf),   32'(exp_ovf));
        $display("[TB] %s: acc=%0d count=%0d ovf=%0d", tag, s_out_acc, s_out_count, s_out_ovf);
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
    endtask

    // Randomized run state (scoreboard)
    longint     m_sum;
    int         m_cnt;
    int         exp_acc_q[$];
    int         exp_cnt_q[$];
    int         exp_ovf_q[$];

    initial begin
        int groups_done;
        int cyc;
        int total;
        logic [15:0] p;

        // Reset values while held in reset
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_acc",   32'(out_acc),   32'(0));
        check("rst_cnt",   32'(out_count), 32'(0));
        check("rst_ovf",   32'(out_ovf),   32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'(1));
        $display("[TB] reset: valid=%0d ready=%0d", out_valid, in_ready);

        // 1. Reset mid-group discards the partial sum
        send(16'd1000, 1'b0);
        send(16'd2000, 1'b0);
        send(16'd3000, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'(0));
        check("midrst_acc",   32'(out_acc),   32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready", 32'(in_ready), 32'(1));
        total = 0;
        for (int i = 0; i < 8; i++) begin
            send(16'(i + 1), 1'b0);
            total += i + 1;
        end
        recv("after_rst", total, 8, 0);

        // 2. Eight maximal 8x8 products, latency of exactly one cycle
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) send(16'd65025, 1'b0);
        check("full_early_valid", 32'(out_valid), 32'(0));
        out_ready = 1'b0;
        send(16'd65025, 1'b0);
        check("full_latency", 32'(out_valid), 32'(1));
        recv("full", 520200, 8, 0);
        check("full_done_valid", 32'(out_valid), 32'(0));
        check("full_done_ready", 32'(in_ready),  32'(1));

        // 3. Early close with in_last, next group starts from zero
        send(16'd10, 1'b0);
        send(16'd20, 1'b0);
        send(16'd30, 1'b1);
        recv("last", 60, 3, 0);
        send(16'd5, 1'b1);
        recv("last_next", 5, 1, 0);

        // 4. Back-pressure: pending result blocks input and stays stable
        send(16'd7, 1'b1);
        in_valid = 1'b1;
        in_prod  = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", 32'(in_ready),  32'(0));
            check("bp_acc",   32'(out_acc),   32'(7));
            check("bp_cnt",   32'(out_count), 32'(1));
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_prod  = '0;
        recv("bp", 7, 1, 0);

        // 5. Reduced accumulator: carry flag and its clearing
        send_s(16'd65025, 1'b0);
        send_s(16'd65025, 1'b0);
        recv_s("ovf", 64514, 2, 1);
        send_s(16'd1, 1'b0);
        send_s(16'd1, 1'b0);
        recv_s("ovf_next", 2, 2, 0);

        // 6. Random valid/ready/last against the group-sum scoreboard
        m_sum = 0;
        m_cnt = 0;
        groups_done = 0;
        cyc = 0;
        while (groups_done < 1000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            p = ($urandom_range(0, 3) == 0) ? 16'd65025 : 16'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_prod   = p;
            in_last   = ($urandom_range(0, 5) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) begin
                m_sum += longint'(p);
                m_cnt++;
                if (m_cnt == 8 || in_last) begin
                    exp_acc_q.push_back(int'(m_sum % (longint'(1) << 24)));
                    exp_cnt_q.push_back(m_cnt);
                    exp_ovf_q.push_back((m_sum >= (longint'(1) << 24)) ? 1 : 0);
                    m_sum = 0;
                    m_cnt = 0;
                end
            end
            if (out_valid && out_ready) begin
                if (exp_acc_q.size() == 0) begin
                    check("rand_spurious", 32'(out_valid), 32'(0));
                end else begin
                    check("rand_acc", 32'(out_acc),   32'(exp_acc_q[0]));
                    check("rand_cnt", 32'(out_count), 32'(exp_cnt_q[0]));
                    check("rand_ovf", 32'(out_ovf),   32'(exp_ovf_q[0]));
                    if (groups_done % 100 == 0)
                        $display("[TB] rand group %0d: acc=%0d count=%0d", groups_done, out_acc, out_count);
                    void'(exp_acc_q.pop_front());
                    void'(exp_cnt_q.pop_front());
                    void'(exp_ovf_q.pop_front());
                end
                groups_done++;
            end
        end
        if (groups_done < 1000) check("rand_timeout", 32'(groups_done), 32'(1000));
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
